// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of LEN words from a first-word-fall-through
// FIFO and forwards them on a valid/ready stream through a 2-entry buffer.
// The final word is marked with OUT_LAST and DONE pulses once it has been
// accepted downstream.
// Optional: define FIFO_BURST_READER_ABORT_EN to add the ABORT input and
// ABORTED output, which cut a burst short.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | popping words from the FIFO into the output buffer
// DRAIN | all words popped, waiting for the buffer to empty downstream
// FIN   | one-cycle DONE pulse
module fifo_burst_reader #(
    parameter int width = 8,
    parameter int lenw  = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [lenw-1:0]  LEN,
    output logic             BUSY,
    output logic             DONE,
    input  logic [width-1:0] FIFO_Q,
    input  logic             FIFO_EMPTY,
    output logic             FIFO_RD,
    output logic [width-1:0] OUT_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             OUT_LAST
`ifdef FIFO_BURST_READER_ABORT_EN
    ,
    input  logic             ABORT,
    output logic             ABORTED
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [lenw-1:0] len_one = lenw'(1);

    state_t           state_q, state_d;
    logic [lenw-1:0]  rem_q;
    logic [lenw-1:0]  ocnt_q;
    logic [width-1:0] buf0_q, buf1_q;
    logic [1:0]       occ_q;
    logic             pop;
    logic             abort_hit;

`ifdef FIFO_BURST_READER_ABORT_EN
    logic aborted_q;

    assign abort_hit = ABORT & ((state_q == RUN) | (state_q == DRAIN));
    assign ABORTED   = aborted_q;

    // Remember that the burst ended by abort; shown only during FIN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            aborted_q <= 1'b0;
        end else if (abort_hit) begin
            aborted_q <= 1'b1;
        end else if (state_q == FIN) begin
            aborted_q <= 1'b0;
        end
    end
`else
    assign abort_hit = 1'b0;
`endif

    assign OUT_VALID = (occ_q != 2'd0);
    assign OUT_DATA  = buf0_q;
    assign pop       = OUT_VALID & OUT_READY;
    // The last word is never flagged in a cycle that is being aborted.
    assign OUT_LAST  = OUT_VALID & (ocnt_q == len_one) & ~abort_hit;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; RUN/DRAIN leave on the edge where their
    // counter reaches zero so DONE follows the final transfer by one cycle.
    always_comb begin
        state_d = state_q;
        FIFO_RD = 1'b0;
        BUSY    = (state_q != IDLE);
        DONE    = (state_q == FIN);
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = (LEN != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                FIFO_RD = (rem_q != '0) & ~FIFO_EMPTY & (occ_q != 2'd2) & ~abort_hit;
                if (abort_hit) begin
                    state_d = FIN;
                end else if ((rem_q == '0) || ((rem_q == len_one) && FIFO_RD)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_hit) begin
                    state_d = FIN;
                end else if ((ocnt_q == '0) || ((ocnt_q == len_one) && pop)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst counters: REM counts pops still owed, OCNT counts transfers still owed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rem_q  <= '0;
            ocnt_q <= '0;
        end else if (abort_hit) begin
            rem_q  <= '0;
            ocnt_q <= '0;
        end else if ((state_q == IDLE) && START) begin
            rem_q  <= LEN;
            ocnt_q <= LEN;
        end else begin
            if (FIFO_RD) begin
                rem_q <= rem_q - len_one;
            end
            if (pop && (ocnt_q != '0)) begin
                ocnt_q <= ocnt_q - len_one;
            end
        end
    end

    // Two-entry in-order output buffer; buf0 is always the head.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf0_q <= '0;
            buf1_q <= '0;
            occ_q  <= 2'd0;
        end else if (abort_hit) begin
            occ_q <= 2'd0;
        end else begin
            case ({FIFO_RD, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        buf0_q <= FIFO_Q;
                    end else begin
                        buf1_q <= FIFO_Q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= FIFO_Q;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= FIFO_Q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench for fifo_burst_reader with a
// behavioural FWFT FIFO and a negedge monitor that logs stream activity.
module tb_fifo_burst_reader;
    localparam int W  = 8;
    localparam int LW = 9;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          OUT_READY = 1'b0;
    logic [LW-1:0] LEN = '0;
    logic          BUSY, DONE, FIFO_EMPTY, FIFO_RD, OUT_VALID, OUT_LAST;
    logic [W-1:0]  FIFO_Q, OUT_DATA;
`ifdef FIFO_BURST_READER_ABORT_EN
    logic          ABORT = 1'b0;
    logic          ABORTED;
`endif

    always #5 CLK = ~CLK;

    fifo_burst_reader #(.width(W), .lenw(LW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BUSY(BUSY), .DONE(DONE),
        .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_LAST(OUT_LAST)
`ifdef FIFO_BURST_READER_ABORT_EN
        , .ABORT(ABORT), .ABORTED(ABORTED)
`endif
    );

    // Behavioural FWFT FIFO
    logic [7:0]  mem [0:1023];
    logic [15:0] wr_ptr = '0;
    logic [15:0] rd_ptr = '0;
    assign FIFO_EMPTY = (wr_ptr == rd_ptr);
    assign FIFO_Q     = mem[rd_ptr[9:0]];
    always @(posedge CLK) if (FIFO_RD) rd_ptr <= rd_ptr + 16'd1;

    int checks = 0;
    int failures = 0;

    // Monitor state (written only by the monitor)
    int cyc = 0, n_rd = 0, n_rd_empty = 0, n_xfer = 0, n_last = 0, n_done = 0;
    int n_busy = 0, n_valid = 0, n_occ_bad = 0, n_full = 0, n_unstable = 0;
    int n_accept = 0, occ_m = 0, done_cyc = 0, accept_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         rd_cyc_log [0:2047];
    logic [7:0] obs_data [0:2047];
    logic       obs_last [0:2047];
    int         obs_cyc [0:2047];

    logic abort_now;
`ifdef FIFO_BURST_READER_ABORT_EN
    assign abort_now = ABORT & BUSY & ~DONE;
`else
    assign abort_now = 1'b0;
`endif

    // Scoreboard state (written only by the test tasks)
    logic [7:0] exp_q[$];
    int obs_rd = 0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (RST) begin
            occ_m      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (FIFO_RD) begin
                rd_cyc_log[n_rd % 2048] <= cyc;
                n_rd <= n_rd + 1;
            end
            if (FIFO_RD && FIFO_EMPTY) n_rd_empty <= n_rd_empty + 1;
            if (OUT_VALID && OUT_READY) begin
                obs_data[n_xfer % 2048] <= OUT_DATA;
                obs_last[n_xfer % 2048] <= OUT_LAST;
                obs_cyc[n_xfer % 2048]  <= cyc;
                n_xfer <= n_xfer + 1;
            end
            if (OUT_VALID && OUT_LAST) n_last <= n_last + 1;
            if (OUT_VALID) n_valid <= n_valid + 1;
            if (BUSY) n_busy <= n_busy + 1;
            if (DONE) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (START && !BUSY) begin
                n_accept   <= n_accept + 1;
                accept_cyc <= cyc;
            end
            if (occ_m > 2 || (occ_m == 2 && FIFO_RD) || (OUT_VALID != (occ_m != 0)))
                n_occ_bad <= n_occ_bad + 1;
            if (occ_m == 2) n_full <= n_full + 1;
            if (prev_stall && !(OUT_VALID && OUT_DATA == prev_data))
                n_unstable <= n_unstable + 1;
            prev_stall <= OUT_VALID && !OUT_READY && !abort_now;
            prev_data  <= OUT_DATA;
            if (abort_now) occ_m <= 0;
            else occ_m <= occ_m + (FIFO_RD ? 1 : 0) - ((OUT_VALID && OUT_READY) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush_fifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr[9:0]] = d;
        wr_ptr = wr_ptr + 16'd1;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        ok = (n_done != d0);
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; OUT_READY = 1'b1;
        flush_fifo();
        push_word(8'h55);
        tick(); tick();
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, FIFO_RD, OUT_VALID, OUT_LAST} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {BUSY, DONE, FIFO_RD, OUT_VALID, OUT_LAST});
        end
        checks++;
        if (OUT_DATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", OUT_DATA);
        end
`ifdef FIFO_BURST_READER_ABORT_EN
        checks++;
        if (ABORTED !== 1'b0) begin
            failures++;
            $display("FAIL reset_aborted got=%b exp=0", ABORTED);
        end
`endif
        @(posedge CLK);
        #1 RST = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if ({BUSY, FIFO_RD} !== 2'b00) begin
            failures++;
            $display("FAIL idle_no_read got=%b exp=00", {BUSY, FIFO_RD});
        end
        tick();
        flush_fifo();
    endtask

    task automatic test_basic();
        int r0, d0, x0, l0;
        bit ok;
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            push_word(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        OUT_READY = 1'b1;
        obs_rd = n_xfer; x0 = n_xfer; r0 = n_rd; d0 = n_done; l0 = n_last;
        START = 1'b1; LEN = 9'd5;
        tick();
        START = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_timeout got=0 exp=1"); end
        tick(); tick(); tick();
        checks++;
        if (n_rd - r0 != 5) begin failures++; $display("FAIL basic_pops got=%0d exp=5", n_rd - r0); end
        checks++;
        if (rd_cyc_log[(r0 + 4) % 2048] - rd_cyc_log[r0 % 2048] != 4) begin
            failures++;
            $display("FAIL basic_rd_consecutive got=%0d exp=4", rd_cyc_log[(r0 + 4) % 2048] - rd_cyc_log[r0 % 2048]);
        end
        checks++;
        if (n_xfer - x0 != 5) begin failures++; $display("FAIL basic_xfers got=%0d exp=5", n_xfer - x0); end
        checks++;
        if (obs_cyc[(x0 + 4) % 2048] - obs_cyc[x0 % 2048] != 4) begin
            failures++;
            $display("FAIL basic_out_consecutive got=%0d exp=4", obs_cyc[(x0 + 4) % 2048] - obs_cyc[x0 % 2048]);
        end
        checks++;
        if (done_cyc != obs_cyc[(x0 + 4) % 2048] + 1) begin
            failures++;
            $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, obs_cyc[(x0 + 4) % 2048] + 1);
        end
        checks++;
        if (n_done - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done - d0); end
        checks++;
        if (n_last - l0 != 1) begin failures++; $display("FAIL basic_last_count got=%0d exp=1", n_last - l0); end
        checks++;
        if (wr_ptr - rd_ptr != 16'd0) begin failures++; $display("FAIL basic_fifo_left got=%0d exp=0", wr_ptr - rd_ptr); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL basic_word got=%h/%b exp=%h/%b", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e, exp_q.size() == 0);
            end
            obs_rd++;
        end
    endtask

    task automatic test_stall();
        int d0, x0, u0, b0, f0;
        bit ok;
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_word(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        obs_rd = n_xfer; x0 = n_xfer; d0 = n_done; u0 = n_unstable; b0 = n_occ_bad; f0 = n_full;
        START = 1'b1; LEN = 9'd3; OUT_READY = pat[0];
        tick();
        START = 1'b0;
        for (int i = 1; i < 6; i++) begin
            OUT_READY = pat[i];
            tick();
        end
        OUT_READY = 1'b1;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_timeout got=0 exp=1"); end
        tick();
        checks++;
        if (n_xfer - x0 != 3) begin failures++; $display("FAIL stall_xfers got=%0d exp=3", n_xfer - x0); end
        checks++;
        if (n_unstable != u0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", n_unstable - u0); end
        checks++;
        if (n_occ_bad != b0) begin failures++; $display("FAIL stall_occ got=%0d exp=0", n_occ_bad - b0); end
        checks++;
        if (n_full - f0 < 1) begin failures++; $display("FAIL stall_full_reached got=%0d exp>=1", n_full - f0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL stall_word got=%h/%b exp=%h/%b", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e, exp_q.size() == 0);
            end
            obs_rd++;
        end
    endtask

    task automatic test_empty_fifo();
        int d0, x0, r0, re0;
        bit ok;
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        OUT_READY = 1'b1;
        obs_rd = n_xfer; x0 = n_xfer; d0 = n_done; r0 = n_rd; re0 = n_rd_empty;
        START = 1'b1; LEN = 9'd4;
        tick();
        START = 1'b0;
        tick(); tick();
        checks++;
        if (n_rd != r0 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL empty_wait got=rd%0d/busy%b exp=rd0/busy1", n_rd - r0, BUSY);
        end
        for (int i = 0; i < 4; i++) begin
            push_word(8'hC0 + 8'(i));
            exp_q.push_back(8'hC0 + 8'(i));
            tick(); tick(); tick();
        end
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL empty_timeout got=0 exp=1"); end
        tick(); tick();
        checks++;
        if (n_rd_empty != re0) begin failures++; $display("FAIL empty_rd_while_empty got=%0d exp=0", n_rd_empty - re0); end
        checks++;
        if (n_xfer - x0 != 4) begin failures++; $display("FAIL empty_xfers got=%0d exp=4", n_xfer - x0); end
        checks++;
        if (n_done - d0 != 1) begin failures++; $display("FAIL empty_done_count got=%0d exp=1", n_done - d0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL empty_word got=%h/%b exp=%h/%b", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e, exp_q.size() == 0);
            end
            obs_rd++;
        end
    endtask

    task automatic test_len_zero();
        int r0, v0, b0, d0;
        flush_fifo();
        push_word(8'h77);
        OUT_READY = 1'b1;
        r0 = n_rd; v0 = n_valid; b0 = n_busy; d0 = n_done;
        START = 1'b1; LEN = 9'd0;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (n_rd != r0) begin failures++; $display("FAIL zero_reads got=%0d exp=0", n_rd - r0); end
        checks++;
        if (n_valid != v0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", n_valid - v0); end
        checks++;
        if (n_busy - b0 != 1) begin failures++; $display("FAIL zero_busy got=%0d exp=1", n_busy - b0); end
        checks++;
        if (n_done - d0 != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", n_done - d0); end
        checks++;
        if (done_cyc != accept_cyc + 1) begin failures++; $display("FAIL zero_done_timing got=%0d exp=%0d", done_cyc, accept_cyc + 1); end
        checks++;
        if (wr_ptr - rd_ptr != 16'd1) begin failures++; $display("FAIL zero_fifo_left got=%0d exp=1", wr_ptr - rd_ptr); end
        flush_fifo();
    endtask

    task automatic test_max_len();
        int r0, d0, x0, a0, l0, b0;
        bit ok;
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        for (int i = 0; i < 513; i++) begin
            push_word(i[7:0]);
            if (i < 511) exp_q.push_back(i[7:0]);
        end
        OUT_READY = 1'b1;
        obs_rd = n_xfer; x0 = n_xfer; r0 = n_rd; d0 = n_done; a0 = n_accept; l0 = n_last; b0 = n_occ_bad;
        START = 1'b1; LEN = 9'd511;
        tick();
        START = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        START = 1'b1; LEN = 9'd3;
        tick();
        START = 1'b0;
        wait_done(d0, 700, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL max_timeout got=0 exp=1"); end
        tick(); tick();
        checks++;
        if (n_rd - r0 != 511) begin failures++; $display("FAIL max_pops got=%0d exp=511", n_rd - r0); end
        checks++;
        if (wr_ptr - rd_ptr != 16'd2 || FIFO_Q !== 8'hFF) begin
            failures++;
            $display("FAIL max_fifo_left got=%0d/%h exp=2/ff", wr_ptr - rd_ptr, FIFO_Q);
        end
        checks++;
        if (n_accept - a0 != 1) begin failures++; $display("FAIL max_start_ignored got=%0d exp=1", n_accept - a0); end
        checks++;
        if (n_last - l0 != 1) begin failures++; $display("FAIL max_last_count got=%0d exp=1", n_last - l0); end
        checks++;
        if (n_xfer - x0 != 511) begin failures++; $display("FAIL max_xfers got=%0d exp=511", n_xfer - x0); end
        checks++;
        if (n_occ_bad != b0) begin failures++; $display("FAIL max_occ got=%0d exp=0", n_occ_bad - b0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL max_word got=%h/%b exp=%h/%b", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e, exp_q.size() == 0);
            end
            obs_rd++;
        end
        flush_fifo();
    endtask

    task automatic test_reset_mid();
        int x0, d0, k;
        bit ok;
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_word(8'h30 + 8'(i));
            exp_q.push_back(8'h30 + 8'(i));
        end
        OUT_READY = 1'b1;
        obs_rd = n_xfer; x0 = n_xfer;
        START = 1'b1; LEN = 9'd8;
        tick();
        START = 1'b0;
        k = 0;
        while (n_xfer - x0 < 3 && k < 50) begin tick(); k++; end
        checks++;
        if (n_xfer - x0 < 3) begin failures++; $display("FAIL rstmid_timeout got=%0d exp=3", n_xfer - x0); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({BUSY, DONE, FIFO_RD, OUT_VALID, OUT_LAST} !== 5'b0 || OUT_DATA !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b/%h exp=00000/00", {BUSY, DONE, FIFO_RD, OUT_VALID, OUT_LAST}, OUT_DATA);
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_word got=%h/%b exp=%h/0", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e);
            end
            obs_rd++;
        end
        exp_q.delete();
        tick();
        flush_fifo();
        push_word(8'hE0); exp_q.push_back(8'hE0);
        push_word(8'hE1); exp_q.push_back(8'hE1);
        obs_rd = n_xfer; x0 = n_xfer; d0 = n_done;
        START = 1'b1; LEN = 9'd2;
        tick();
        START = 1'b0;
        wait_done(d0, 50, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_restart_timeout got=0 exp=1"); end
        tick();
        checks++;
        if (n_xfer - x0 != 2) begin failures++; $display("FAIL rstmid_restart_xfers got=%0d exp=2", n_xfer - x0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e || obs_last[obs_rd % 2048] !== (exp_q.size() == 0)) begin
                failures++;
                $display("FAIL rstmid_restart_word got=%h/%b exp=%h/%b", obs_data[obs_rd % 2048], obs_last[obs_rd % 2048], e, exp_q.size() == 0);
            end
            obs_rd++;
        end
    endtask

`ifdef FIFO_BURST_READER_ABORT_EN
    task automatic test_abort();
        int x0, d0, l0, k;
        logic [7:0] e;
        flush_fifo();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            push_word(8'h60 + 8'(i));
            exp_q.push_back(8'h60 + 8'(i));
        end
        OUT_READY = 1'b1;
        obs_rd = n_xfer; x0 = n_xfer; d0 = n_done; l0 = n_last;
        START = 1'b1; LEN = 9'd8;
        tick();
        START = 1'b0;
        k = 0;
        while (n_xfer - x0 < 3 && k < 50) begin tick(); k++; end
        checks++;
        if (n_xfer - x0 < 3) begin failures++; $display("FAIL abort_timeout got=%0d exp=3", n_xfer - x0); end
        ABORT = 1'b1;
        @(negedge CLK);
        checks++;
        if (FIFO_RD !== 1'b0) begin failures++; $display("FAIL abort_rd got=%b exp=0", FIFO_RD); end
        tick();
        ABORT = 1'b0;
        @(negedge CLK);
        checks++;
        if ({OUT_VALID, DONE, ABORTED} !== 3'b011) begin
            failures++;
            $display("FAIL abort_end got=%b exp=011", {OUT_VALID, DONE, ABORTED});
        end
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_data[obs_rd % 2048] !== e) begin
                failures++;
                $display("FAIL abort_word got=%h exp=%h", obs_data[obs_rd % 2048], e);
            end
            obs_rd++;
        end
        exp_q.delete();
        tick(); tick();
        checks++;
        if (n_last != l0 || n_done - d0 != 1 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL abort_after got=last%0d/done%0d/busy%b exp=last0/done1/busy0", n_last - l0, n_done - d0, BUSY);
        end
        d0 = n_done;
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        tick();
        checks++;
        if (n_done != d0 || ABORTED !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle_ignored got=done%0d/ab%b exp=done0/ab0", n_done - d0, ABORTED);
        end
        flush_fifo();
        obs_rd = n_xfer;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty_fifo();
        test_len_zero();
        test_max_len();
        test_reset_mid();
`ifdef FIFO_BURST_READER_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
